// File: rtl/mem_port_arbiter.sv
// Two-port arbiter that owns the 16 x 8 program/data memory: one access per clock,
// round-robin between the CPU sequencer (port 0) and the loader/debug port (port 1), with a bounded bus lock.
module mem_port_arbiter #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic              p0_lock_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic              p1_lock_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p0_gnt_o,
    output logic              p1_gnt_o,
    output logic              p0_rvalid_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              lock_err_o
);

    // state      | meaning
    // S_UNLOCKED | round-robin between both ports
    // S_LOCKED   | only owner_q may be granted; cnt_q counts edges held

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic {
        S_UNLOCKED = 1'b0,
        S_LOCKED   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               gnt0, gnt1, any_gnt, sel;
    logic               acc_we, acc_lock, owner_lock;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (state_q == S_LOCKED) begin
                gnt0 = !owner_q && p0_req_i;
                gnt1 = owner_q && p1_req_i;
            end else if (p0_req_i && p1_req_i) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = p0_req_i;
                gnt1 = p1_req_i;
            end
        end
    end

    assign any_gnt    = gnt0 | gnt1;
    assign sel        = gnt1;
    assign acc_we     = sel ? p1_we_i    : p0_we_i;
    assign acc_lock   = sel ? p1_lock_i  : p0_lock_i;
    assign acc_addr   = sel ? p1_addr_i  : p0_addr_i;
    assign acc_wdata  = sel ? p1_wdata_i : p0_wdata_i;
    assign owner_lock = owner_q ? p1_lock_i : p0_lock_i;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        if (any_gnt) begin
            last_d = sel;
            if (!acc_we) begin
                if (sel) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = mem_q[acc_addr];
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = mem_q[acc_addr];
                end
            end
        end

        case (state_q)
            S_UNLOCKED: begin
                if (any_gnt && acc_lock) begin
                    state_d = S_LOCKED;
                    owner_d = sel;
                    cnt_d   = '0;
                end
            end
            S_LOCKED: begin
                if (!owner_lock) begin
                    state_d = S_UNLOCKED;
                end else if (cnt_q == CNT_LAST) begin
                    // Forced release hands the next tie to the port that was shut out.
                    state_d = S_UNLOCKED;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_UNLOCKED;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (any_gnt && acc_we) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    assign p0_gnt_o    = gnt0;
    assign p1_gnt_o    = gnt1;
    assign p0_rvalid_o = rvalid0_q;
    assign p1_rvalid_o = rvalid1_q;
    assign p0_rdata_o  = rdata0_q;
    assign p1_rdata_o  = rdata1_q;
    assign lock_err_o  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected read data is queued per port when a read
// is expected to be granted and checked against rvalid/rdata on the following cycle.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
    logic [3:0] p0_addr, p1_addr;
    logic [7:0] p0_wdata, p1_wdata;
    logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, lock_err;
    logic [7:0] p0_rdata, p1_rdata;

    logic [7:0] model [16];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(8), .ADDR_W(4), .LOCK_MAX(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_lock_i(p0_lock),
        .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_lock_i(p1_lock),
        .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p0_gnt_o(p0_gnt), .p1_gnt_o(p1_gnt),
        .p0_rvalid_o(p0_rvalid), .p1_rvalid_o(p1_rvalid),
        .p0_rdata_o(p0_rdata), .p1_rdata_o(p1_rdata),
        .lock_err_o(lock_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic req, input logic we, input logic lk,
                        input logic [3:0] a, input logic [7:0] d);
        p0_req = req; p0_we = we; p0_lock = lk; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set1(input logic req, input logic we, input logic lk,
                        input logic [3:0] a, input logic [7:0] d);
        p1_req = req; p1_we = we; p1_lock = lk; p1_addr = a; p1_wdata = d;
    endtask

    // One clock: check last cycle's read results, this cycle's grants and lock_err, then advance.
    task automatic do_cycle(input logic eg0, input logic eg1, input logic eerr);
        logic [7:0] d;
        logic rv0, rv1;
        @(negedge clk);
        rv0 = (q0.size() > 0);
        rv1 = (q1.size() > 0);
        chk("p0_rvalid", {31'b0, p0_rvalid}, {31'b0, rv0});
        if (rv0) begin
            d = q0.pop_front();
            chk("p0_rdata", {24'b0, p0_rdata}, {24'b0, d});
        end
        chk("p1_rvalid", {31'b0, p1_rvalid}, {31'b0, rv1});
        if (rv1) begin
            d = q1.pop_front();
            chk("p1_rdata", {24'b0, p1_rdata}, {24'b0, d});
        end
        chk("p0_gnt", {31'b0, p0_gnt}, {31'b0, eg0});
        chk("p1_gnt", {31'b0, p1_gnt}, {31'b0, eg1});
        chk("lock_err", {31'b0, lock_err}, {31'b0, eerr});
        if (eg0) begin
            if (p0_we) model[p0_addr] = p0_wdata;
            else q0.push_back(model[p0_addr]);
        end
        if (eg1) begin
            if (p1_we) model[p1_addr] = p1_wdata;
            else q1.push_back(model[p1_addr]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        do_cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'hFF;
        set0(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        set0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        chk("p0_rdata_after_rst", {24'b0, p0_rdata}, 32'h0);
        chk("p1_rdata_after_rst", {24'b0, p1_rdata}, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            set0(1'b1, 1'b0, 1'b0, 4'(i), 8'h00);
            do_cycle(1'b1, 1'b0, 1'b0);
        end
        set0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b0);

        // p1 writes, p0 reads back next cycle
        set1(1'b1, 1'b1, 1'b0, 4'd3, 8'hA5);
        do_cycle(1'b0, 1'b1, 1'b0);
        set1(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        set0(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        do_cycle(1'b1, 1'b0, 1'b0);
        set0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b0);

        // Round robin from a fresh reset: p0 wins the first tie
        do_reset();
        set0(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        for (int k = 0; k < 6; k++) do_cycle(k % 2 == 0, k % 2 == 1, 1'b0);
        set0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        set1(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b0);

        // Locked read-modify-write
        set1(1'b1, 1'b1, 1'b0, 4'd7, 8'h11);
        do_cycle(1'b0, 1'b1, 1'b0);
        set1(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        set0(1'b1, 1'b0, 1'b1, 4'd7, 8'h00);
        do_cycle(1'b1, 1'b0, 1'b0);
        set0(1'b0, 1'b0, 1'b1, 4'd7, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b0, 1'b0);
        set0(1'b1, 1'b1, 1'b0, 4'd7, 8'h22);
        do_cycle(1'b1, 1'b0, 1'b0);
        set0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b0);
        set1(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b0);

        // Lock timeout: p0 acquires and idles holding lock
        set0(1'b1, 1'b0, 1'b1, 4'd0, 8'h00);
        do_cycle(1'b1, 1'b0, 1'b0);
        set0(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
        for (int k = 1; k <= 8; k++) do_cycle(1'b0, 1'b0, 1'b0);
        set0(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b1);
        set1(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b1, 1'b0, 1'b0);
        set0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b0);

        // Reset while p0 holds the lock
        set1(1'b1, 1'b1, 1'b0, 4'd9, 8'h5A);
        do_cycle(1'b0, 1'b1, 1'b0);
        set0(1'b1, 1'b0, 1'b1, 4'd1, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
        do_cycle(1'b1, 1'b0, 1'b0);
        set0(1'b0, 1'b0, 1'b1, 4'd1, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b0);
        do_reset();
        set0(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b0);
        set1(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
